// File: rtl/cache_pkg.sv
// Shared definitions for the cache request controller slice.
// Holds the address-split geometry, the set-side state encodings
// and the controller FSM state type.
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 3;
    localparam int INDEX_W  = 4;
    localparam int TAG_W    = 25;
    localparam int NUM_SETS = 1 << INDEX_W;
    localparam int DATA_W   = 64;
    localparam int CNT_W    = 32;

    // Encoding of the set_state line seen by every cache_set
    localparam logic STATE_SEARCH = 1'b0;
    localparam logic STATE_UPDATE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        UPDATE = 2'd2,
        RESP   = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/cache_addr_split.sv
// Combinational split of a reference address into tag and set index.
// The byte offset within the line is not needed by the sets.
// Ports:
//   addr_i  : full reference address
//   tag_o   : upper TAG_W bits
//   index_o : INDEX_W bits directly above the offset
module cache_addr_split #(
    parameter int ADDR_W   = cache_pkg::ADDR_W,
    parameter int OFFSET_W = cache_pkg::OFFSET_W,
    parameter int INDEX_W  = cache_pkg::INDEX_W,
    parameter int TAG_W    = cache_pkg::TAG_W
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [TAG_W-1:0]   tag_o,
    output logic [INDEX_W-1:0] index_o
);

    logic unused_offset;

    assign tag_o         = addr_i[ADDR_W-1 -: TAG_W];
    assign index_o       = addr_i[OFFSET_W +: INDEX_W];
    assign unused_offset = ^addr_i[OFFSET_W-1:0];

endmodule

// File: rtl/cache_request_ctrl.sv
// Request-side controller in front of the cache_set array.
// Takes one address at a time, walks the selected set through a search
// cycle and an update cycle, then holds the hit/miss response until the
// requester takes it. Running hit and miss counters are kept.
// Every output is driven straight from a register.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr/
//   req_fill_data                     : request handshake, address, miss fill line
//   resp_valid/resp_ready/resp_hit/
//   resp_data                         : response handshake, hit flag, hit data
//   set_enable/set_state/set_mem_write/
//   set_tag/set_write_data            : drive to the set array
//   set_hit/set_read_data             : per-set results
//   hit_count/miss_count              : running totals (wrap on overflow)
//
// state  | meaning
// IDLE   | ready for a request, sets idle
// SEARCH | selected set compares its tags
// UPDATE | selected set updates; hit/data captured
// RESP   | response held until resp_ready
module cache_request_ctrl #(
    parameter int ADDR_W   = cache_pkg::ADDR_W,
    parameter int OFFSET_W = cache_pkg::OFFSET_W,
    parameter int INDEX_W  = cache_pkg::INDEX_W,
    parameter int TAG_W    = cache_pkg::TAG_W,
    parameter int DATA_W   = cache_pkg::DATA_W,
    parameter int CNT_W    = cache_pkg::CNT_W,
    localparam int NUM_SETS = 1 << INDEX_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_fill_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_hit,
    output logic [DATA_W-1:0]          resp_data,
    output logic [NUM_SETS-1:0]        set_enable,
    output logic                       set_state,
    output logic                       set_mem_write,
    output logic [TAG_W-1:0]           set_tag,
    output logic [DATA_W-1:0]          set_write_data,
    input  logic [NUM_SETS-1:0]        set_hit,
    input  logic [NUM_SETS*DATA_W-1:0] set_read_data,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count
);

    import cache_pkg::*;

    ctrl_state_e         state_q;
    logic [INDEX_W-1:0]  index_q;
    logic [DATA_W-1:0]   fill_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic                resp_hit_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [NUM_SETS-1:0] set_enable_q;
    logic                set_state_q;
    logic                set_mem_write_q;
    logic [TAG_W-1:0]    set_tag_q;
    logic [DATA_W-1:0]   set_write_data_q;
    logic [CNT_W-1:0]    hit_count_q;
    logic [CNT_W-1:0]    miss_count_q;

    logic [TAG_W-1:0]    req_tag_d;
    logic [INDEX_W-1:0]  req_index_d;
    logic                sel_hit;
    logic [DATA_W-1:0]   sel_data;

    cache_addr_split #(
        .ADDR_W  (ADDR_W),
        .OFFSET_W(OFFSET_W),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_addr_split (
        .addr_i (req_addr),
        .tag_o  (req_tag_d),
        .index_o(req_index_d)
    );

    // Only the latched set's result counts; other sets' hit lines are ignored.
    assign sel_hit  = set_hit[index_q];
    assign sel_data = set_read_data[int'(index_q)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            index_q          <= '0;
            fill_q           <= '0;
            req_ready_q      <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_hit_q       <= 1'b0;
            resp_data_q      <= '0;
            set_enable_q     <= '0;
            set_state_q      <= STATE_UPDATE;
            set_mem_write_q  <= 1'b0;
            set_tag_q        <= '0;
            set_write_data_q <= '0;
            hit_count_q      <= '0;
            miss_count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        state_q      <= SEARCH;
                        index_q      <= req_index_d;
                        fill_q       <= req_fill_data;
                        req_ready_q  <= 1'b0;
                        set_enable_q <= NUM_SETS'(1) << req_index_d;
                        set_state_q  <= STATE_SEARCH;
                        set_tag_q    <= req_tag_d;
                    end
                end
                SEARCH: begin
                    state_q          <= UPDATE;
                    set_state_q      <= STATE_UPDATE;
                    // Write is never gated on hit: the set decides whether to update.
                    set_mem_write_q  <= 1'b1;
                    set_write_data_q <= fill_q;
                end
                UPDATE: begin
                    state_q         <= RESP;
                    set_enable_q    <= '0;
                    set_mem_write_q <= 1'b0;
                    resp_valid_q    <= 1'b1;
                    resp_hit_q      <= sel_hit;
                    resp_data_q     <= sel_hit ? sel_data : '0;
                    if (sel_hit) begin
                        hit_count_q <= hit_count_q + CNT_W'(1);
                    end else begin
                        miss_count_q <= miss_count_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    req_ready_q     <= 1'b0;
                    resp_valid_q    <= 1'b0;
                    set_enable_q    <= '0;
                    set_state_q     <= STATE_UPDATE;
                    set_mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign resp_data      = resp_data_q;
    assign set_enable     = set_enable_q;
    assign set_state      = set_state_q;
    assign set_mem_write  = set_mem_write_q;
    assign set_tag        = set_tag_q;
    assign set_write_data = set_write_data_q;
    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_cache_request_ctrl.sv
module tb_cache_request_ctrl;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [63:0]   req_fill_data;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_hit;
    logic [63:0]   resp_data;
    logic [15:0]   set_enable;
    logic          set_state;
    logic          set_mem_write;
    logic [24:0]   set_tag;
    logic [63:0]   set_write_data;
    logic [15:0]   set_hit;
    logic [1023:0] set_read_data;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;

    int checks = 0;
    int errors = 0;

    cache_request_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_fill_data (req_fill_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_hit      (resp_hit),
        .resp_data     (resp_data),
        .set_enable    (set_enable),
        .set_state     (set_state),
        .set_mem_write (set_mem_write),
        .set_tag       (set_tag),
        .set_write_data(set_write_data),
        .set_hit       (set_hit),
        .set_read_data (set_read_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read-data bus where every set returns a distinct junk pattern and the
    // addressed set returns 'slice'.
    function automatic logic [1023:0] make_rd(input int idx, input logic [63:0] slice);
        logic [1023:0] rd;
        for (int k = 0; k < 16; k++) rd[k*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(k + 1);
        rd[idx*64 +: 64] = slice;
        return rd;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"},  64'(req_ready), 64'd0);
        chk({pfx, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({pfx, "_set_enable"}, 64'(set_enable), 64'd0);
        chk({pfx, "_set_state"},  64'(set_state), 64'd1);
        chk({pfx, "_mem_write"},  64'(set_mem_write), 64'd0);
        chk({pfx, "_hit_count"},  64'(hit_count), 64'd0);
        chk({pfx, "_miss_count"}, 64'(miss_count), 64'd0);
    endtask

    // One full transaction; expected values come from the caller.
    task automatic do_req(input string nm, input logic [31:0] addr, input logic [63:0] fill,
                          input logic [15:0] hitv, input logic [1023:0] rd,
                          input logic [15:0] exp_en, input logic [24:0] exp_tag,
                          input logic exp_hit, input logic [63:0] exp_data,
                          input logic [31:0] exp_hits, input logic [31:0] exp_misses,
                          input int bp_cycles);
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_fill_data = fill;
        set_hit = '0;
        @(negedge clk);
        req_valid = 1'b0;
        chk({nm, "_srch_en"},    64'(set_enable), 64'(exp_en));
        chk({nm, "_srch_state"}, 64'(set_state), 64'd0);
        chk({nm, "_srch_tag"},   64'(set_tag), 64'(exp_tag));
        chk({nm, "_srch_ready"}, 64'(req_ready), 64'd0);
        set_hit = hitv; set_read_data = rd;
        @(negedge clk);
        chk({nm, "_upd_en"},    64'(set_enable), 64'(exp_en));
        chk({nm, "_upd_state"}, 64'(set_state), 64'd1);
        chk({nm, "_upd_wr"},    64'(set_mem_write), 64'd1);
        chk({nm, "_upd_wdata"}, set_write_data, fill);
        @(negedge clk);
        chk({nm, "_resp_valid"}, 64'(resp_valid), 64'd1);
        chk({nm, "_resp_hit"},   64'(resp_hit), 64'(exp_hit));
        chk({nm, "_resp_data"},  resp_data, exp_data);
        chk({nm, "_hits"},       64'(hit_count), 64'(exp_hits));
        chk({nm, "_misses"},     64'(miss_count), 64'(exp_misses));
        chk({nm, "_resp_en"},    64'(set_enable), 64'd0);
        for (int c = 0; c < bp_cycles; c++) begin
            req_valid = 1'b1; req_addr = 32'h0000_0100; set_hit = '1;
            @(negedge clk);
            chk({nm, "_bp_valid"}, 64'(resp_valid), 64'd1);
            chk({nm, "_bp_hit"},   64'(resp_hit), 64'(exp_hit));
            chk({nm, "_bp_data"},  resp_data, exp_data);
            chk({nm, "_bp_ready"}, 64'(req_ready), 64'd0);
            chk({nm, "_bp_en"},    64'(set_enable), 64'd0);
        end
        req_valid = 1'b0; set_hit = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, "_done_valid"}, 64'(resp_valid), 64'd0);
        chk({nm, "_done_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        chk({nm, "_idle_en"},     64'(set_enable), 64'd0);
        chk({nm, "_idle_hits"},   64'(hit_count), 64'(exp_hits));
        chk({nm, "_idle_misses"}, 64'(miss_count), 64'(exp_misses));
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_fill_data = '0;
        resp_ready = 1'b0; set_hit = '0; set_read_data = '0;

        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        chk("rst_resp_hit",  64'(resp_hit), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        // cold miss: index 1, tag 1
        do_req("cold", 32'h0000_0088, 64'h1111_2222_3333_4444, 16'h0000,
               make_rd(1, 64'h0123_4567_89AB_CDEF),
               16'h0002, 25'h1, 1'b0, 64'd0, 32'd0, 32'd1, 0);

        // repeat hit with 5 cycles of backpressure
        do_req("hit", 32'h0000_0088, 64'h5555_6666_7777_8888, 16'h0002,
               make_rd(1, 64'hDEAD_BEEF_CAFE_F00D),
               16'h0002, 25'h1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 32'd1, 32'd1, 5);

        // top index / all-ones tag
        do_req("hi_edge", 32'hFFFF_FFF8, 64'h0F0F_0F0F_0F0F_0F0F, 16'h0000,
               make_rd(15, 64'h0),
               16'h8000, 25'h1FF_FFFF, 1'b0, 64'd0, 32'd1, 32'd2, 0);

        // bottom index / zero tag, offset bits all set
        do_req("lo_edge", 32'h0000_0007, 64'hF0F0_F0F0_F0F0_F0F0, 16'h0000,
               make_rd(0, 64'h0),
               16'h0001, 25'h0, 1'b0, 64'd0, 32'd1, 32'd3, 0);

        // stray hit from set 3 while set 1 is addressed
        do_req("stray", 32'h0000_0088, 64'h0, 16'h0008,
               make_rd(1, 64'h1234_5678_9ABC_DEF0),
               16'h0002, 25'h1, 1'b0, 64'd0, 32'd1, 32'd4, 0);

        // reset while the set is in UPDATE
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0088; req_fill_data = 64'h9;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_in_update", 64'(set_mem_write), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid");
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ready", 64'(req_ready), 64'd1);

        do_req("after", 32'h0000_0088, 64'h0, 16'h0002,
               make_rd(1, 64'hFEED_FACE_0000_0001),
               16'h0002, 25'h1, 1'b1, 64'hFEED_FACE_0000_0001, 32'd1, 32'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
